multi_tick_generator: RTL and testbench



---
 rtl/multi_tick_generator_if.sv | 25 ++
 rtl/multi_tick_generator.sv | 74 +++++++
 tb/tb_multi_tick_generator.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_tick_generator_if.sv
// Control/status bundle for the multi-channel tick generator.
// master drives the channel controls, slave is the generator itself.
interface multi_tick_generator_if #(
   parameter int NCH   = 2,
   parameter int WIDTH = 32
);
   logic [NCH-1:0]       en;
   logic [NCH-1:0]       restart;
   logic [NCH-1:0]       oneshot;
   logic [NCH-1:0]       div_load;
   logic [NCH*WIDTH-1:0] div_value;
   logic [NCH-1:0]       tick;
   logic [NCH-1:0]       done;
   logic [NCH-1:0]       busy;

   modport master (
      output en, restart, oneshot, div_load, div_value,
      input  tick, done, busy
   );

   modport slave (
      input  en, restart, oneshot, div_load, div_value,
      output tick, done, busy
   );
endinterface

// File: rtl/multi_tick_generator.sv
// NCH independent clock-enable dividers with periodic/one-shot modes,
// restart, pause and runtime-loadable divisors; all outputs registered.
module multi_tick_generator #(
   parameter int NCH         = 2,
   parameter int WIDTH       = 32,
   parameter int DEFAULT_MAX = 100
) (
   input logic                   clk,
   input logic                   rst,
   multi_tick_generator_if.slave bus
);
   localparam logic [WIDTH-1:0] DMAX = WIDTH'(DEFAULT_MAX);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [NCH-1:0][WIDTH-1:0] count_q, count_d;
   logic [NCH-1:0][WIDTH-1:0] div_q, div_d;
   logic [NCH-1:0]            armed_q, armed_d;
   logic [NCH-1:0]            done_q, done_d;
   logic [NCH-1:0]            tick_q, tick_d;

   always_comb begin
      count_d = count_q;
      div_d   = div_q;
      armed_d = armed_q;
      done_d  = done_q;
      tick_d  = '0;
      for (int i = 0; i < NCH; i++) begin
         // Divisor update is independent of restart; 0 would never tick.
         if (bus.div_load[i]) begin
            if (bus.div_value[i*WIDTH +: WIDTH] == '0)
               div_d[i] = ONE;
            else
               div_d[i] = bus.div_value[i*WIDTH +: WIDTH];
         end
         if (bus.restart[i]) begin
            count_d[i] = '0;
            done_d[i]  = 1'b0;
            armed_d[i] = 1'b1;
         end else if (bus.en[i] && armed_q[i]) begin
            // >= so a shrunk divisor wraps immediately instead of locking up
            if (count_q[i] >= div_q[i] - ONE) begin
               count_d[i] = '0;
               tick_d[i]  = 1'b1;
               if (bus.oneshot[i]) begin
                  armed_d[i] = 1'b0;
                  done_d[i]  = 1'b1;
               end
            end else begin
               count_d[i] = count_q[i] + ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         div_q   <= {NCH{DMAX}};
         armed_q <= '1;
         done_q  <= '0;
         tick_q  <= '0;
      end else begin
         count_q <= count_d;
         div_q   <= div_d;
         armed_q <= armed_d;
         done_q  <= done_d;
         tick_q  <= tick_d;
      end
   end

   assign bus.tick = tick_q;
   assign bus.done = done_q;
   assign bus.busy = armed_q;
endmodule

// File: tb/tb_multi_tick_generator.sv
// Self-checking bench: directed timing scenarios plus random traffic,
// all checked cycle by cycle against an enabled-cycle-counting model.
module tb_multi_tick_generator;
   localparam int NCH = 2;
   localparam int W   = 32;
   localparam int DM  = 100;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   multi_tick_generator_if #(.NCH(NCH), .WIDTH(W)) bus ();

   multi_tick_generator #(
      .NCH(NCH), .WIDTH(W), .DEFAULT_MAX(DM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Model: per channel, enabled edges seen since the last arm/wrap.
   longint m_el   [NCH];
   longint m_dv   [NCH];
   bit     m_arm  [NCH];
   bit     m_done [NCH];
   bit     m_tick [NCH];

   always @(posedge clk) begin : model
      longint nd;
      for (int c = 0; c < NCH; c++) begin
         if (rst) begin
            m_el[c]   = 0;
            m_dv[c]   = DM;
            m_arm[c]  = 1;
            m_done[c] = 0;
            m_tick[c] = 0;
         end else begin
            nd = m_dv[c];
            if (bus.div_load[c]) begin
               nd = longint'(bus.div_value[c*W +: W]);
               if (nd == 0) nd = 1;
            end
            m_tick[c] = 0;
            if (bus.restart[c]) begin
               m_el[c]   = 0;
               m_done[c] = 0;
               m_arm[c]  = 1;
            end else if (bus.en[c] && m_arm[c]) begin
               if (m_el[c] + 1 >= m_dv[c]) begin
                  m_el[c]   = 0;
                  m_tick[c] = 1;
                  if (bus.oneshot[c]) begin
                     m_arm[c]  = 0;
                     m_done[c] = 1;
                  end
               end else begin
                  m_el[c] = m_el[c] + 1;
               end
            end
            m_dv[c] = nd;
         end
      end
   end

   task automatic step();
      logic [NCH-1:0] et, ed, eb;
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
         et[c] = m_tick[c];
         ed[c] = m_done[c];
         eb[c] = m_arm[c];
      end
      n_cmp++;
      if (bus.tick !== et || bus.done !== ed || bus.busy !== eb) begin
         n_bad++;
         $display("FAIL model t=%0t tick %b want %b done %b want %b busy %b want %b",
                  $time, bus.tick, et, bus.done, ed, bus.busy, eb);
      end
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic wait_tick(input int ch, input int bound, output int n);
      n = -1;
      for (int i = 1; i <= bound; i++) begin
         step();
         if (bus.tick[ch]) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic clr_pulses();
      bus.restart  = '0;
      bus.div_load = '0;
   endtask

   task automatic setdiv(input int ch, input int v);
      bus.div_load[ch]          = 1'b1;
      bus.div_value[ch*W +: W]  = W'(v);
   endtask

   initial begin
      int n, first, cnt;
      rst           = 1'b1;
      bus.en        = 2'b01;
      bus.restart   = '0;
      bus.oneshot   = '0;
      bus.div_load  = '0;
      bus.div_value = '0;
      step();
      rst = 1'b0;

      // Default divisor, periodic on ch0
      wait_tick(0, 150, n);
      chk("t1_first", n, 100);
      chk("t1_busy", bus.busy[0], 1);
      chk("t1_done", bus.done[0], 0);
      wait_tick(0, 150, n);
      chk("t1_second", n, 100);
      wait_tick(0, 150, n);
      chk("t1_third", n, 100);

      // One-shot on ch1
      bus.en = '0;
      setdiv(1, 5);
      bus.oneshot[1] = 1'b1;
      bus.restart[1] = 1'b1;
      step();
      clr_pulses();
      bus.en[1] = 1'b1;
      wait_tick(1, 20, n);
      chk("t2_shot", n, 5);
      chk("t2_done", bus.done[1], 1);
      chk("t2_busy", bus.busy[1], 0);
      cnt = 0;
      repeat (50) begin
         step();
         cnt += int'(bus.tick[1]);
      end
      chk("t2_quiet", cnt, 0);
      bus.restart[1] = 1'b1;
      step();
      clr_pulses();
      chk("t2_rs_done", bus.done[1], 0);
      wait_tick(1, 20, n);
      chk("t2_reshot", n, 5);
      bus.en[1] = 1'b0;
      bus.oneshot[1] = 1'b0;

      // Pause pattern on ch0
      setdiv(0, 10);
      bus.restart[0] = 1'b1;
      step();
      clr_pulses();
      first = -1;
      for (int k = 0; k < 40 && first < 0; k++) begin
         bus.en[0] = ((k / 3) % 2 == 0);
         step();
         if (bus.tick[0]) first = k;
      end
      chk("t3_pause", first, 18);

      // Divisor shrink below current count
      setdiv(0, 100);
      bus.restart[0] = 1'b1;
      bus.en[0] = 1'b1;
      step();
      clr_pulses();
      repeat (60) step();
      setdiv(0, 20);
      step();
      clr_pulses();
      chk("t4_load_edge", bus.tick[0], 0);
      wait_tick(0, 5, n);
      chk("t4_wrap", n, 1);
      wait_tick(0, 40, n);
      chk("t4_period", n, 20);

      // Zero divisor acts as 1; restart+load same edge
      setdiv(0, 0);
      step();
      clr_pulses();
      cnt = 0;
      repeat (8) begin
         step();
         cnt += int'(bus.tick[0]);
      end
      chk("t5_div0", cnt, 8);
      setdiv(0, 3);
      bus.restart[0] = 1'b1;
      step();
      clr_pulses();
      chk("t5_rs_tick", bus.tick[0], 0);
      wait_tick(0, 10, n);
      chk("t5_rs_load", n, 3);

      // Reset mid-count
      setdiv(0, 50);
      setdiv(1, 2);
      bus.oneshot[1] = 1'b1;
      bus.restart = 2'b11;
      bus.en = '0;
      step();
      clr_pulses();
      bus.en = 2'b11;
      repeat (7) step();
      chk("t6_pre_done", bus.done[1], 1);
      rst = 1'b1;
      step();
      chk("t6_tick", bus.tick, 0);
      chk("t6_done", bus.done, 0);
      chk("t6_busy", bus.busy, 3);
      rst = 1'b0;
      bus.en = 2'b01;
      bus.oneshot = '0;
      wait_tick(0, 150, n);
      chk("t6_default", n, 100);

      // Random traffic on both channels
      setdiv(0, 4);
      setdiv(1, 7);
      step();
      clr_pulses();
      for (int i = 0; i < 4000; i++) begin
         for (int c = 0; c < NCH; c++) begin
            bus.en[c]       = ($urandom_range(0, 3) != 0);
            bus.restart[c]  = ($urandom_range(0, 24) == 0);
            bus.div_load[c] = ($urandom_range(0, 14) == 0);
            bus.div_value[c*W +: W] = W'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) bus.oneshot[c] = ~bus.oneshot[c];
         end
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;
      clr_pulses();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
